cnn_layer_sequencer: RTL
========================

Name: cnn_layer_sequencer

Overview:
Parametrised next-generation CNN layer controller. Reads a layer-count header and per-layer 3-word descriptors from memory over a one-word read handshake. Decodes each layer and dispatches it to one of three compute engines (conv, pool, fully-connected) with fully computed operand addresses and geometry. Ping-pongs feature maps between two buffers, checks descriptors and reports errors. Sits between the host/top level and the layer engines, replacing ad-hoc inline address arithmetic.

Parameters:
DATA_W, 16, descriptor/data word width
ADDR_W, 16, memory address width
MAX_LAYERS, 16, maximum accepted layer count
CNT_W, 8, width of layer index and feature-map counts

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; accepted only in IDLE
cfg_layer_addr  in  ADDR_W  address of header word (layer count)
cfg_img_addr  in  ADDR_W  input image base
cfg_img_size  in  DATA_W  input image side S
cfg_img_count  in  CNT_W  input feature-map count C
cfg_buf_a  in  ADDR_W  ping buffer base
cfg_buf_b  in  ADDR_W  pong buffer base
mem_rd_req  out  1  read request, held until mem_rd_valid
mem_rd_addr  out  ADDR_W  read address, stable while req high
mem_rd_valid  in  1  one-cycle data-valid; completes request
mem_rd_data  in  DATA_W  read data
eng_start  out  3  one-hot start pulse {fc,pool,conv}
eng_done  in  3  one-hot done pulse from engines
eng_img_addr, eng_out_addr, eng_wgt_addr  out  ADDR_W  engine operands
eng_img_size, eng_win_size  out  DATA_W  S and K
eng_img_count, eng_filt_count  out  CNT_W  C and N
busy  out  1  high outside IDLE/DONE/ERROR
done  out  1  level, high in DONE until next start
error  out  1  level, high in ERROR until next start
err_code  out  3  1=bad count, 2=bad type, 3=bad window, 4=address overflow
layer_idx  out  CNT_W  current layer index

Behaviour:
- Reset: state IDLE; every output 0 (including mem_rd_addr, all eng_* operands, layer_idx, err_code). Reset mid-operation aborts immediately; a late mem_rd_valid/eng_done is ignored.
- States: IDLE, RD_HDR, RD_DESC, CHECK, DISPATCH, WAIT_ENG, UPDATE, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch cfg_*; clear done/error/err_code; layer_idx=0; desc_ptr=cfg_layer_addr+1; cur_img=cfg_img_addr; S=cfg_img_size; C=cfg_img_count; out buffer = buf_a. Go to RD_HDR. start in any other state is ignored.
- RD_HDR: read cfg_layer_addr. L==0 or L>MAX_LAYERS -> ERROR code 1; else RD_DESC.
- RD_DESC: three sequential reads desc_ptr+0..2 -> type, K, N. Each request is raised the cycle after the previous valid. Minimum 2 cycles per word.
- Type field (low 2 bits): 0=pool, 1=conv, 2=fc, 3 -> ERROR code 2. Upper bits are ignored.
- CHECK (1 cycle). Error code 3 when:
  - conv: K==0, K even, or K>S.
  - pool: K==0 or K>S.
  - fc: always passes (K ignored).
- Weight length W, computed at 2*ADDR_W:
  - conv: K*K*N*C+N
  - fc: S*S*C*N+N
  - pool: 0
- next_ptr = desc_ptr+3+W. Exceeding 2^ADDR_W-1 -> ERROR code 4.
- DISPATCH: drive operands:
  - eng_img_addr = cur_img
  - eng_out_addr = current ping/pong base
  - eng_wgt_addr = desc_ptr+3
  - S, K, C, N as decoded
- DISPATCH, pulse: eng_start one-hot for one cycle; operands held stable until UPDATE.
- WAIT_ENG: wait for eng_done bit matching the dispatched engine; other bits are ignored. No timeout.
- UPDATE (1 cycle), geometry:
  - conv: S=S-(K-1), C=N
  - pool: S=S/K (floor), C unchanged
  - fc: S=1, C=N
- UPDATE, addressing: cur_img=out base; toggle ping/pong; desc_ptr=next_ptr; layer_idx+=1.
- UPDATE, exit: layer_idx==L -> DONE; else RD_DESC.
- All arithmetic is unsigned, truncated to the port width except where the overflow check applies.

Decomposition:
- Package cnn_seq_pkg: state enum, layer-type enum (POOL/CONV/FC), err_code localparams, engine one-hot index constants.
- One sub-module: cnn_desc_decoder. Combinational; takes type/K/N/S/C/desc_ptr and returns engine select, error code, weight pointer, next_ptr, next S/C.

Test Plan:
- Header L=2: conv (K=3,N=4) then pool (K=2); S=32, C=1, layer_addr=0x100, buf_a=0x2000, buf_b=0x3000.
  - Conv dispatch: wgt=0x104, img=cfg_img_addr, out=0x2000.
  - Pool dispatch: S=30, C=4, img=0x2000, out=0x3000, desc read at 0x104+40=0x12C.
  - End: done=1.
- Header L=0 -> error=1, err_code=1, no eng_start. Header L=17 with MAX_LAYERS=16 -> err_code=1.
- Descriptor type=3 -> err_code=2. Conv K=4 -> err_code=3. Pool K=5 with S=4 -> err_code=3.
- Memory returns valid 7 cycles after req: mem_rd_addr stable throughout, exactly 4 reads for L=1, no duplicate requests.
- fc after conv: S=1 on completion. Spurious eng_done for the wrong engine while waiting -> ignored, no state change.
- Reset asserted in WAIT_ENG, then eng_done arrives -> all outputs 0, state IDLE. Fresh start completes a normal run.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer.
// Holds the FSM state encoding, the layer-type field values,
// the error codes reported on err_code and the bit positions
// of each engine in the one-hot eng_start/eng_done vectors.
package cnn_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_RD_HDR, S_RD_DESC, S_CHECK, S_DISPATCH,
      S_WAIT_ENG, S_UPDATE, S_DONE, S_ERROR
   } state_t;

   typedef enum logic [1:0] {
      LT_POOL = 2'd0,
      LT_CONV = 2'd1,
      LT_FC   = 2'd2
   } layer_t;

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_COUNT  = 3'd1;
   localparam logic [2:0] ERR_TYPE   = 3'd2;
   localparam logic [2:0] ERR_WINDOW = 3'd3;
   localparam logic [2:0] ERR_ADDR   = 3'd4;

   // bit positions in {fc,pool,conv}
   localparam int ENG_CONV = 0;
   localparam int ENG_POOL = 1;
   localparam int ENG_FC   = 2;

endpackage

// File: rtl/cnn_desc_decoder.sv
// Combinational layer-descriptor decoder.
// Inputs : i_type (low 2 bits of descriptor word 0), i_k window size,
//          i_n filter count, i_s / i_c current feature-map side and count,
//          i_desc_ptr address of descriptor word 0.
// Outputs: o_eng_sel one-hot engine {fc,pool,conv}, o_err error code
//          (0 = ok), o_wgt_ptr weight base, o_next_ptr next descriptor,
//          o_next_s / o_next_c geometry after this layer.
module cnn_desc_decoder
   import cnn_seq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic [1:0]        i_type,
   input  logic [DATA_W-1:0] i_k,
   input  logic [CNT_W-1:0]  i_n,
   input  logic [DATA_W-1:0] i_s,
   input  logic [CNT_W-1:0]  i_c,
   input  logic [ADDR_W-1:0] i_desc_ptr,
   output logic [2:0]        o_eng_sel,
   output logic [2:0]        o_err,
   output logic [ADDR_W-1:0] o_wgt_ptr,
   output logic [ADDR_W-1:0] o_next_ptr,
   output logic [DATA_W-1:0] o_next_s,
   output logic [CNT_W-1:0]  o_next_c
);

   localparam int WW = 2 * ADDR_W;
   // two spare bits so ptr+3+W can never wrap before the range check
   localparam int PW = WW + 2;

   logic [WW-1:0] w_k, w_n, w_s, w_c, w_wlen;
   logic [PW-1:0] w_next_full;

   assign w_k = WW'(i_k);
   assign w_n = WW'(i_n);
   assign w_s = WW'(i_s);
   assign w_c = WW'(i_c);

   assign o_wgt_ptr  = i_desc_ptr + ADDR_W'(3);
   assign o_next_ptr = w_next_full[ADDR_W-1:0];

   always_comb begin
      o_eng_sel   = '0;
      o_err       = ERR_NONE;
      w_wlen      = '0;
      o_next_s    = i_s;
      o_next_c    = i_c;
      case (i_type)
         2'(LT_CONV): begin
            o_eng_sel[ENG_CONV] = 1'b1;
            if (i_k == '0 || !i_k[0] || i_k > i_s) o_err = ERR_WINDOW;
            w_wlen   = w_k * w_k * w_n * w_c + w_n;
            o_next_s = i_s - i_k + DATA_W'(1);
            o_next_c = i_n;
         end
         2'(LT_POOL): begin
            o_eng_sel[ENG_POOL] = 1'b1;
            if (i_k == '0 || i_k > i_s) o_err = ERR_WINDOW;
            // guard keeps the divider defined on the error path
            o_next_s = (i_k == '0) ? i_s : i_s / i_k;
         end
         2'(LT_FC): begin
            o_eng_sel[ENG_FC] = 1'b1;
            w_wlen   = w_s * w_s * w_c * w_n + w_n;
            o_next_s = DATA_W'(1);
            o_next_c = i_n;
         end
         default: o_err = ERR_TYPE;
      endcase
      w_next_full = PW'(i_desc_ptr) + PW'(3) + PW'(w_wlen);
      if (o_err == ERR_NONE && w_next_full > PW'({ADDR_W{1'b1}}))
         o_err = ERR_ADDR;
   end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// CNN layer sequencer: fetches a layer-count header and 3-word layer
// descriptors over a one-word read handshake, validates each layer,
// dispatches it to the conv/pool/fc engine with computed operand
// addresses and ping-pongs feature maps between two buffers.
// Ports: clk/reset (sync, active high); start + cfg_* run setup;
//        mem_rd_* descriptor read port; eng_start/eng_done one-hot
//        engine handshake {fc,pool,conv}; eng_* operand outputs;
//        busy/done/error/err_code/layer_idx status.
module cnn_layer_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int MAX_LAYERS = 16,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_layer_addr,
   input  logic [ADDR_W-1:0] cfg_img_addr,
   input  logic [DATA_W-1:0] cfg_img_size,
   input  logic [CNT_W-1:0]  cfg_img_count,
   input  logic [ADDR_W-1:0] cfg_buf_a,
   input  logic [ADDR_W-1:0] cfg_buf_b,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [2:0]        eng_start,
   input  logic [2:0]        eng_done,
   output logic [ADDR_W-1:0] eng_img_addr,
   output logic [ADDR_W-1:0] eng_out_addr,
   output logic [ADDR_W-1:0] eng_wgt_addr,
   output logic [DATA_W-1:0] eng_img_size,
   output logic [DATA_W-1:0] eng_win_size,
   output logic [CNT_W-1:0]  eng_img_count,
   output logic [CNT_W-1:0]  eng_filt_count,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code,
   output logic [CNT_W-1:0]  layer_idx
);

   state_t r_state, w_next;

   logic [ADDR_W-1:0] r_layer_addr, r_buf_a, r_buf_b, r_desc_ptr, r_cur_img;
   logic [DATA_W-1:0] r_s, r_k;
   logic [CNT_W-1:0]  r_c, r_n, r_l, r_layer_idx;
   logic [1:0]        r_type, r_word;
   logic              r_pp;       // 0: output to buf_a, 1: output to buf_b
   logic [2:0]        r_err_code;
   logic [ADDR_W-1:0] r_eng_img, r_eng_out, r_eng_wgt;
   logic [DATA_W-1:0] r_eng_s, r_eng_k;
   logic [CNT_W-1:0]  r_eng_c, r_eng_n;

   logic [2:0]        w_eng_sel, w_err;
   logic [ADDR_W-1:0] w_wgt_ptr, w_next_ptr;
   logic [DATA_W-1:0] w_next_s;
   logic [CNT_W-1:0]  w_next_c;
   logic              w_hdr_bad, w_last, w_idle_like;

   cnn_desc_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dec (
      .i_type     (r_type),
      .i_k        (r_k),
      .i_n        (r_n),
      .i_s        (r_s),
      .i_c        (r_c),
      .i_desc_ptr (r_desc_ptr),
      .o_eng_sel  (w_eng_sel),
      .o_err      (w_err),
      .o_wgt_ptr  (w_wgt_ptr),
      .o_next_ptr (w_next_ptr),
      .o_next_s   (w_next_s),
      .o_next_c   (w_next_c)
   );

   assign w_hdr_bad   = (mem_rd_data == '0) || (mem_rd_data > DATA_W'(MAX_LAYERS));
   assign w_last      = (r_layer_idx + CNT_W'(1)) == r_l;
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_RD_HDR;
         S_RD_HDR:   if (mem_rd_valid) w_next = w_hdr_bad ? S_ERROR : S_RD_DESC;
         S_RD_DESC:  if (mem_rd_valid && r_word == 2'd2) w_next = S_CHECK;
         S_CHECK:    w_next = (w_err != ERR_NONE) ? S_ERROR : S_DISPATCH;
         S_DISPATCH: w_next = S_WAIT_ENG;
         S_WAIT_ENG: if ((eng_done & w_eng_sel) != 3'b000) w_next = S_UPDATE;
         S_UPDATE:   w_next = w_last ? S_DONE : S_RD_DESC;
         default:    w_next = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      mem_rd_req  = 1'b0;
      mem_rd_addr = '0;
      eng_start   = 3'b000;
      case (r_state)
         S_RD_HDR: begin
            mem_rd_req  = 1'b1;
            mem_rd_addr = r_layer_addr;
         end
         S_RD_DESC: begin
            mem_rd_req  = 1'b1;
            mem_rd_addr = r_desc_ptr + ADDR_W'(r_word);
         end
         S_DISPATCH: eng_start = w_eng_sel;
         default: ;
      endcase
      busy  = !w_idle_like;
      done  = (r_state == S_DONE);
      error = (r_state == S_ERROR);
   end

   // datapath; decoder inputs stay frozen from CHECK through UPDATE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_layer_addr <= '0; r_buf_a <= '0; r_buf_b <= '0;
         r_desc_ptr   <= '0; r_cur_img <= '0;
         r_s <= '0; r_k <= '0; r_c <= '0; r_n <= '0; r_l <= '0;
         r_type <= '0; r_word <= '0; r_pp <= 1'b0;
         r_layer_idx <= '0; r_err_code <= ERR_NONE;
         r_eng_img <= '0; r_eng_out <= '0; r_eng_wgt <= '0;
         r_eng_s <= '0; r_eng_k <= '0; r_eng_c <= '0; r_eng_n <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) begin
               r_layer_addr <= cfg_layer_addr;
               r_buf_a      <= cfg_buf_a;
               r_buf_b      <= cfg_buf_b;
               r_desc_ptr   <= cfg_layer_addr + ADDR_W'(1);
               r_cur_img    <= cfg_img_addr;
               r_s          <= cfg_img_size;
               r_c          <= cfg_img_count;
               r_pp         <= 1'b0;
               r_word       <= 2'd0;
               r_layer_idx  <= '0;
               r_err_code   <= ERR_NONE;
            end
            S_RD_HDR: if (mem_rd_valid) begin
               r_l <= mem_rd_data[CNT_W-1:0];
               if (w_hdr_bad) r_err_code <= ERR_COUNT;
            end
            S_RD_DESC: if (mem_rd_valid) begin
               case (r_word)
                  2'd0:    r_type <= mem_rd_data[1:0];
                  2'd1:    r_k    <= mem_rd_data;
                  default: r_n    <= mem_rd_data[CNT_W-1:0];
               endcase
               r_word <= (r_word == 2'd2) ? 2'd0 : r_word + 2'd1;
            end
            S_CHECK: begin
               if (w_err != ERR_NONE) begin
                  r_err_code <= w_err;
               end else begin
                  r_eng_img <= r_cur_img;
                  r_eng_out <= r_pp ? r_buf_b : r_buf_a;
                  r_eng_wgt <= w_wgt_ptr;
                  r_eng_s   <= r_s;
                  r_eng_k   <= r_k;
                  r_eng_c   <= r_c;
                  r_eng_n   <= r_n;
               end
            end
            S_UPDATE: begin
               r_s         <= w_next_s;
               r_c         <= w_next_c;
               r_cur_img   <= r_pp ? r_buf_b : r_buf_a;
               r_pp        <= !r_pp;
               r_desc_ptr  <= w_next_ptr;
               r_layer_idx <= r_layer_idx + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign eng_img_addr   = r_eng_img;
   assign eng_out_addr   = r_eng_out;
   assign eng_wgt_addr   = r_eng_wgt;
   assign eng_img_size   = r_eng_s;
   assign eng_win_size   = r_eng_k;
   assign eng_img_count  = r_eng_c;
   assign eng_filt_count = r_eng_n;
   assign err_code       = r_err_code;
   assign layer_idx      = r_layer_idx;

endmodule
